dmem_responder: RTL

//  Responder side of the MEM-stage data-memory interface: accepts one load/store

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_array.sv | 40 ++++
 rtl/dmem_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package dmem_pkg;

  localparam int unsigned DATA_W              = 32;
  localparam int unsigned ADDR_BITS           = 32;
  localparam int unsigned BYTE_OFF_W          = 2;
  localparam int unsigned CNT_W               = 4;
  localparam int unsigned MAX_WAIT_CYCLES     = 15;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
  localparam int unsigned DEFAULT_ADDR_W      = 10;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic                 we;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_W-1:0]    wdata;
  } req_t;

  // Byte address is bad if it is not word aligned or lies beyond the array.
  function automatic logic addr_err(input logic [ADDR_BITS-1:0] addr,
                                    input int unsigned addr_w);
    logic [63:0]          span;
    logic [ADDR_BITS-1:0] ok_mask;
    span    = (64'd1 << (addr_w + BYTE_OFF_W)) - 64'd1;
    ok_mask = ADDR_BITS'(span) & ~ADDR_BITS'((2 ** BYTE_OFF_W) - 1);
    return |(addr & ~ok_mask);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array; read data is registered and reads as zero
// except in the cycle after a read strobe.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned ADDR_W      = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_W-1:0] r_rdata;

  // Storage is deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end else begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one outstanding access, fixed wait
// states, one-cycle response pulse and a pipeline stall.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [DATA_W-1:0]    resp_rdata,
  output logic                 resp_err,
  output logic                 stall
);

  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  if (WAIT_CYCLES > MAX_WAIT_CYCLES) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end
  if (DEPTH_WORDS != (32'd1 << ADDR_W)) begin : g_bad_depth
    $error("dmem_responder: DEPTH_WORDS must equal 2**ADDR_W");
  end

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  req_t              r_req;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_resp_err;

  req_t              w_live;
  req_t              w_acc;
  logic              w_accept;
  logic              w_enter_resp;
  logic              w_acc_err;
  logic              w_arr_we;
  logic              w_arr_re;
  logic [ADDR_W-1:0] w_idx;
  logic [DATA_W-1:0] w_arr_rdata;

  assign w_live = '{we: req_we, addr: req_addr, wdata: req_wdata};

  // With no wait states the access commits on the accept edge, so use the live request.
  assign w_acc        = ZERO_WAIT ? w_live : r_req;
  assign w_accept     = (r_state == ST_IDLE) & req_valid;
  assign w_enter_resp = ZERO_WAIT ? w_accept
                                  : ((r_state == ST_WAIT) & (r_cnt == CNT_W'(1)));
  assign w_acc_err    = addr_err(w_acc.addr, ADDR_W);
  assign w_idx        = w_acc.addr[ADDR_W+1:2];
  assign w_arr_we     = w_enter_resp & w_acc.we & ~w_acc_err & rst_n;
  assign w_arr_re     = w_enter_resp & ~w_acc.we & ~w_acc_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_req        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_req       <= w_live;
            r_cnt       <= CNT_W'(WAIT_CYCLES);
            r_req_ready <= 1'b0;
            if (ZERO_WAIT) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= w_acc_err;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_enter_resp) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_acc_err;
          end
        end
        ST_RESP: begin
          r_state      <= ST_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_arr_we),
    .i_re   (w_arr_re),
    .i_idx  (w_idx),
    .i_wdata(w_acc.wdata),
    .o_rdata(w_arr_rdata)
  );

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = w_arr_rdata;
  // Released in RESP so the pipeline advances on the response edge.
  assign stall      = (r_state == ST_WAIT) | ((r_state == ST_IDLE) & req_valid);

endmodule
